// File: rtl/register_file_sb_pkg.sv
// ============================================================================
// register_file_sb_pkg : shared widths for decode, register file and writeback
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_sb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/register_file_sb_scoreboard.sv
// ============================================================================
// register_file_sb_scoreboard : pending-load bits, pending count, busy flags
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sb_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam logic BYP = (BYPASS != 0);

    logic [NREGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             set_w, clr_w, inc_w, dec_w;

    // Bit 0 is never set, so r0 can never report busy.
    always_comb begin
        set_w  = issue_en && (issue_rd != '0);
        clr_w  = wr1_en && (wr1_addr != '0);
        pend_d = pend_q;
        if (clr_w) pend_d[wr1_addr] = 1'b0;
        if (set_w) pend_d[issue_rd] = 1'b1;

        inc_w = set_w && !pend_q[issue_rd];
        dec_w = clr_w && pend_q[wr1_addr] && !(set_w && (issue_rd == wr1_addr));
        cnt_d = cnt_q;
        if (inc_w && !dec_w)
            cnt_d = cnt_q + 1'b1;
        else if (dec_w && !inc_w)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busyA    = pend_q[rs1] & ~(BYP & wr1_en & (wr1_addr == rs1));
    assign busyB    = pend_q[rs2] & ~(BYP & wr1_en & (wr1_addr == rs2));
    assign pend_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// register_file_sb : NREGS x DATA_W register file, 2R/2W, load scoreboard
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    output logic              busyA,
    output logic              busyB,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              collision
);

    localparam logic BYP = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              collision_q, collision_d;

    assign collision_d = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != '0);

    // wr1 is applied after wr0 so it wins an address tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            collision_q <= 1'b0;
        end else begin
            if (wr0_en && (wr0_addr != '0)) regs_q[wr0_addr] <= wr0_data;
            if (wr1_en && (wr1_addr != '0)) regs_q[wr1_addr] <= wr1_data;
            collision_q <= collision_d;
        end
    end

    // Forwarding priority: wr1 over wr0 over stored; r0 forced to zero last.
    always_comb begin
        regA = regs_q[rs1];
        if (BYP && wr0_en && (wr0_addr == rs1)) regA = wr0_data;
        if (BYP && wr1_en && (wr1_addr == rs1)) regA = wr1_data;
        if (rs1 == '0) regA = '0;

        regB = regs_q[rs2];
        if (BYP && wr0_en && (wr0_addr == rs2)) regB = wr0_data;
        if (BYP && wr1_en && (wr1_addr == rs2)) regB = wr1_data;
        if (rs2 == '0) regB = '0;
    end

    assign collision = collision_q;

    register_file_sb_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .busyA    (busyA),
        .busyB    (busyB),
        .pend_cnt (pend_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// tb_register_file_sb : bench for register_file_sb, BYPASS=1 and BYPASS=0
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  rs1, rs2, wr0_addr, wr1_addr, issue_rd;
    logic [15:0] wr0_data, wr1_data;
    logic        wr0_en, wr1_en, issue_en;

    logic [15:0] regA_b, regB_b, regA_n, regB_n;
    logic        busyA_b, busyB_b, busyA_n, busyB_n;
    logic [3:0]  pend_cnt_b, pend_cnt_n;
    logic        collision_b, collision_n;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: architectural contents, pending set, last-cycle collision.
    int unsigned mem  [8];
    bit          pend [8];
    bit          col_m;

    always #5 clk = ~clk;

    register_file_sb #(.DATA_W(16), .NREGS(8), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2),
        .regA(regA_b), .regB(regB_b), .busyA(busyA_b), .busyB(busyB_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .pend_cnt(pend_cnt_b), .collision(collision_b)
    );

    register_file_sb #(.DATA_W(16), .NREGS(8), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2),
        .regA(regA_n), .regB(regB_n), .busyA(busyA_n), .busyB(busyB_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .pend_cnt(pend_cnt_n), .collision(collision_n)
    );

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 0;
            pend[i] = 0;
        end
        col_m = 0;
    endfunction

    function automatic int unsigned exp_rd(input int addr, input bit byp);
        if (addr == 0) return 0;
        if (byp && wr1_en && wr1_addr == addr) return wr1_data;
        if (byp && wr0_en && wr0_addr == addr) return wr0_data;
        return mem[addr];
    endfunction

    function automatic bit exp_busy(input int addr, input bit byp);
        return (addr != 0) && pend[addr] && !(byp && wr1_en && wr1_addr == addr);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        foreach (pend[i]) c += pend[i];
        return c;
    endfunction

    // Advance one edge, applying the architectural rules to the reference state.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            col_m = wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != 0;
            if (wr0_en && wr0_addr != 0) mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) mem[wr1_addr] = wr1_data;
            if (wr1_en && wr1_addr != 0) pend[wr1_addr] = 0;
            if (issue_en && issue_rd != 0) pend[issue_rd] = 1;
        end
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; issue_en = 0;
        wr0_addr = 0; wr1_addr = 0; issue_rd = 0;
        wr0_data = 0; wr1_data = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        rs1 = 0; rs2 = 0;
        model_reset();
        #2;
        for (int r = 0; r < 8; r++) begin
            rs1 = 3'(r); rs2 = 3'(7 - r);
            #1;
            n_vec++;
            if (regA_b !== 16'h0 || regB_b !== 16'h0 || busyA_b !== 1'b0 || busyB_b !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_read r%0d: regA=%h regB=%h busyA=%b busyB=%b, required 0", r, regA_b, regB_b, busyA_b, busyB_b);
            end
        end
        n_vec++;
        if (pend_cnt_b !== 4'd0 || pend_cnt_n !== 4'd0 || collision_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cnt: pend_cnt=%0d/%0d collision=%b, required 0", pend_cnt_b, pend_cnt_n, collision_b);
        end
        tick();
        reset_n = 1;
    endtask

    task automatic test_bypass();
        idle();
        wr0_en = 1; wr0_addr = 3; wr0_data = 16'h1234; rs1 = 3; rs2 = 0;
        #2;
        n_vec++;
        if (regA_b !== 16'h1234) begin
            n_bad++; $display("FAIL bypass_fwd: regA=%h, required 1234", regA_b);
        end
        n_vec++;
        if (regA_n !== 16'h0000) begin
            n_bad++; $display("FAIL nobypass_old: regA=%h, required 0000", regA_n);
        end
        tick();
        idle();
        #2;
        n_vec++;
        if (regA_b !== 16'h1234 || regA_n !== 16'h1234) begin
            n_bad++; $display("FAIL bypass_next: regA=%h/%h, required 1234", regA_b, regA_n);
        end
    endtask

    task automatic test_collision();
        idle();
        wr0_en = 1; wr0_addr = 5; wr0_data = 16'hAAAA;
        wr1_en = 1; wr1_addr = 5; wr1_data = 16'h5555;
        rs1 = 5;
        #2;
        n_vec++;
        if (regA_b !== 16'h5555 || collision_b !== 1'b0) begin
            n_bad++; $display("FAIL coll_fwd: regA=%h collision=%b, required 5555/0", regA_b, collision_b);
        end
        tick();
        idle();
        #2;
        n_vec++;
        if (collision_b !== 1'b1 || collision_n !== 1'b1 || regA_n !== 16'h5555) begin
            n_bad++; $display("FAIL coll_pulse: collision=%b/%b regA=%h, required 1/1/5555", collision_b, collision_n, regA_n);
        end
        tick();
        n_vec++;
        if (collision_b !== 1'b0) begin
            n_bad++; $display("FAIL coll_once: collision=%b, required 0", collision_b);
        end
        wr0_en = 1; wr0_addr = 0; wr0_data = 16'hFFFF;
        wr1_en = 1; wr1_addr = 0; wr1_data = 16'hEEEE;
        rs1 = 0;
        #2;
        n_vec++;
        if (regA_b !== 16'h0) begin
            n_bad++; $display("FAIL r0_fwd: regA=%h, required 0000", regA_b);
        end
        tick();
        idle();
        #2;
        n_vec++;
        if (collision_b !== 1'b0 || regA_b !== 16'h0 || regA_n !== 16'h0) begin
            n_bad++; $display("FAIL r0_coll: collision=%b regA=%h/%h, required 0/0/0", collision_b, regA_b, regA_n);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1; issue_rd = 2;
        tick();
        idle();
        rs1 = 2;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++;
            if (busyA_b !== 1'b1 || busyA_n !== 1'b1 || pend_cnt_b !== 4'd1) begin
                n_bad++; $display("FAIL busy_hold c%0d: busyA=%b/%b pend_cnt=%0d, required 1/1/1", c, busyA_b, busyA_n, pend_cnt_b);
            end
            tick();
        end
        wr1_en = 1; wr1_addr = 2; wr1_data = 16'h00FF;
        #2;
        n_vec++;
        if (busyA_b !== 1'b0 || regA_b !== 16'h00FF) begin
            n_bad++; $display("FAIL load_fwd: busyA=%b regA=%h, required 0/00ff", busyA_b, regA_b);
        end
        n_vec++;
        if (busyA_n !== 1'b1) begin
            n_bad++; $display("FAIL load_nobyp_busy: busyA=%b, required 1", busyA_n);
        end
        tick();
        idle();
        #2;
        n_vec++;
        if (pend_cnt_b !== 4'd0 || busyA_n !== 1'b0 || regA_n !== 16'h00FF) begin
            n_bad++; $display("FAIL load_done: pend_cnt=%0d busyA=%b regA=%h, required 0/0/00ff", pend_cnt_b, busyA_n, regA_n);
        end
    endtask

    task automatic test_set_clear();
        idle();
        issue_en = 1; issue_rd = 4;
        tick();
        wr1_en = 1; wr1_addr = 4; wr1_data = 16'h4444;
        tick();
        idle();
        rs1 = 4;
        #2;
        n_vec++;
        if (busyA_b !== 1'b1 || pend_cnt_b !== 4'd1 || regA_b !== 16'h4444) begin
            n_bad++; $display("FAIL set_wins: busyA=%b pend_cnt=%0d regA=%h, required 1/1/4444", busyA_b, pend_cnt_b, regA_b);
        end
        issue_en = 1; issue_rd = 0;
        tick();
        idle();
        n_vec++;
        if (pend_cnt_b !== 4'd1 || pend_cnt_n !== 4'd1) begin
            n_bad++; $display("FAIL issue_r0: pend_cnt=%0d/%0d, required 1", pend_cnt_b, pend_cnt_n);
        end
        wr1_en = 1; wr1_addr = 4; wr1_data = 16'h0;
        tick();
        idle();
    endtask

    task automatic test_fill_drain();
        idle();
        for (int r = 1; r < 8; r++) begin
            issue_en = 1; issue_rd = 3'(r);
            tick();
            n_vec++;
            if (pend_cnt_b !== 4'(r)) begin
                n_bad++; $display("FAIL fill r%0d: pend_cnt=%0d, required %0d", r, pend_cnt_b, r);
            end
        end
        issue_rd = 1;
        tick();
        n_vec++;
        if (pend_cnt_b !== 4'd7 || pend_cnt_n !== 4'd7) begin
            n_bad++; $display("FAIL reissue: pend_cnt=%0d/%0d, required 7", pend_cnt_b, pend_cnt_n);
        end
        idle();
        for (int r = 1; r < 8; r++) begin
            wr1_en = 1; wr1_addr = 3'(r); wr1_data = 16'($urandom);
            tick();
            n_vec++;
            if (pend_cnt_b !== 4'(7 - r)) begin
                n_bad++; $display("FAIL drain r%0d: pend_cnt=%0d, required %0d", r, pend_cnt_b, 7 - r);
            end
        end
        wr1_addr = 1;
        tick();
        n_vec++;
        if (pend_cnt_b !== 4'd0 || pend_cnt_n !== 4'd0) begin
            n_bad++; $display("FAIL underflow: pend_cnt=%0d/%0d, required 0", pend_cnt_b, pend_cnt_n);
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bit narrow = ($urandom_range(0, 3) == 0);
            wr0_en   = $urandom_range(0, 1);
            wr1_en   = $urandom_range(0, 2) == 0;
            issue_en = $urandom_range(0, 2) != 0;
            wr0_addr = narrow ? 3'($urandom_range(0, 1)) : 3'($urandom);
            wr1_addr = narrow ? 3'($urandom_range(0, 1)) : 3'($urandom);
            issue_rd = 3'($urandom);
            wr0_data = 16'($urandom);
            wr1_data = 16'($urandom);
            rs1 = 3'($urandom);
            rs2 = narrow ? wr1_addr : 3'($urandom);
            #2;
            n_vec++;
            if (regA_b !== 16'(exp_rd(rs1, 1)) || regB_b !== 16'(exp_rd(rs2, 1))) begin
                n_bad++; $display("FAIL rnd_read_byp k%0d: regA=%h regB=%h, required %h %h", k, regA_b, regB_b, 16'(exp_rd(rs1, 1)), 16'(exp_rd(rs2, 1)));
            end
            n_vec++;
            if (regA_n !== 16'(exp_rd(rs1, 0)) || regB_n !== 16'(exp_rd(rs2, 0))) begin
                n_bad++; $display("FAIL rnd_read_nobyp k%0d: regA=%h regB=%h, required %h %h", k, regA_n, regB_n, 16'(exp_rd(rs1, 0)), 16'(exp_rd(rs2, 0)));
            end
            n_vec++;
            if (busyA_b !== exp_busy(rs1, 1) || busyB_b !== exp_busy(rs2, 1) ||
                busyA_n !== exp_busy(rs1, 0) || busyB_n !== exp_busy(rs2, 0)) begin
                n_bad++; $display("FAIL rnd_busy k%0d: byp=%b%b nobyp=%b%b, required %b%b %b%b", k, busyA_b, busyB_b, busyA_n, busyB_n,
                                  exp_busy(rs1, 1), exp_busy(rs2, 1), exp_busy(rs1, 0), exp_busy(rs2, 0));
            end
            n_vec++;
            if (pend_cnt_b !== 4'(exp_cnt()) || pend_cnt_n !== 4'(exp_cnt()) ||
                collision_b !== col_m || collision_n !== col_m) begin
                n_bad++; $display("FAIL rnd_state k%0d: pend_cnt=%0d/%0d collision=%b/%b, required %0d/%b", k, pend_cnt_b, pend_cnt_n,
                                  collision_b, collision_n, exp_cnt(), col_m);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        wr0_en = 1; wr0_addr = 6; wr0_data = 16'hBEEF;
        issue_en = 1; issue_rd = 6;
        tick();
        idle();
        rs1 = 6; rs2 = 6;
        #2;
        n_vec++;
        if (regA_n !== 16'hBEEF || busyA_n !== 1'b1 || pend_cnt_n === 4'd0) begin
            n_bad++; $display("FAIL pre_reset: regA=%h busyA=%b pend_cnt=%0d, required beef/1/nonzero", regA_n, busyA_n, pend_cnt_n);
        end
        reset_n = 0;
        model_reset();
        wr0_en = 1; wr0_addr = 3; wr0_data = 16'hCAFE;
        issue_en = 1; issue_rd = 5;
        #1;
        n_vec++;
        if (regA_n !== 16'h0 || regB_b !== 16'h0 || busyA_n !== 1'b0 || pend_cnt_b !== 4'd0 || pend_cnt_n !== 4'd0 || collision_b !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: regA=%h regB=%h busyA=%b pend_cnt=%0d/%0d collision=%b, required all 0",
                              regA_n, regB_b, busyA_n, pend_cnt_b, pend_cnt_n, collision_b);
        end
        tick();
        reset_n = 1;
        idle();
        rs1 = 3; rs2 = 5;
        #2;
        n_vec++;
        if (regA_b !== 16'h0 || regA_n !== 16'h0 || busyB_b !== 1'b0 || pend_cnt_b !== 4'd0) begin
            n_bad++; $display("FAIL reset_discard: regA=%h/%h busyB=%b pend_cnt=%0d, required 0", regA_b, regA_n, busyB_b, pend_cnt_b);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_set_clear();
        test_fill_drain();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
